// File: rtl/reg_file_ctrl_pkg.sv
// Shared definitions for the register-file command controller: opcodes,
// FSM state encoding and default widths.
package reg_ctrl_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDR_WIDTH     = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    RD_SEND = 3'd5
  } state_e;

endpackage

// File: rtl/reg_file_ctrl_cmd_timer.sv
// Partial-frame timeout counter: clears on any accepted byte or when disabled,
// and flags expiry once TIMEOUT_CYCLES-1 idle cycles have been counted.
module cmd_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A byte in the expiry cycle wins, so clr masks the expiry flag.
  assign expired = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_file_ctrl.sv
// Byte-command controller in front of the register file: parses AA/addr/data
// writes and BB/addr reads, returns read data to the transmitter.
// Optional partial-frame timeout is built when CMD_TIMEOUT_EN is defined.
module reg_file_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  output logic                  CMD_ERR
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  cmd_err_q, cmd_err_d;

  logic addr_valid;
  logic is_wr_cmd;
  logic is_rd_cmd;
  logic timeout;

  assign addr_valid = (RX_P_DATA >> ADDR_WIDTH) == '0;
  assign is_wr_cmd  = RX_P_DATA == DATA_WIDTH'(WR_CMD);
  assign is_rd_cmd  = RX_P_DATA == DATA_WIDTH'(RD_CMD);

`ifdef CMD_TIMEOUT_EN
  logic timer_en;

  assign timer_en = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR);

  cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_cmd_timer (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (RX_D_VLD),
    .en     (timer_en),
    .expired(timeout)
  );
`else
  // No counter in this build; the comparison is constant-false and only
  // keeps TIMEOUT_CYCLES referenced.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (is_wr_cmd) begin
            state_d = WR_ADDR;
          end else if (is_rd_cmd) begin
            state_d = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          state_d = addr_valid ? WR_DATA : IDLE;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD || timeout) begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          state_d = addr_valid ? RD_WAIT : IDLE;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      RD_WAIT: state_d = RD_SEND;
      RD_SEND: begin
        if (!TX_BUSY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    tx_vld_d  = 1'b0;
    cmd_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RX_D_VLD && !is_wr_cmd && !is_rd_cmd) begin
          cmd_err_d = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_valid) begin
            addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          end else begin
            cmd_err_d = 1'b1;
          end
        end else if (timeout) begin
          cmd_err_d = 1'b1;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
        end else if (timeout) begin
          cmd_err_d = 1'b1;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_valid) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else if (timeout) begin
          cmd_err_d = 1'b1;
        end
      end
      RD_WAIT: begin
        cmd_err_d = RX_D_VLD;
      end
      RD_SEND: begin
        // Stray bytes are dropped but the pending read still completes.
        cmd_err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_data_d = RF_RdData;
          tx_vld_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign RF_Address = addr_q;
  assign RF_WrData  = wr_data_q;
  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Scoreboard bench for reg_file_ctrl: directed byte frames push expected
// strobes (with cycle stamps) into queues; a negedge monitor pops and compares.
module tb_reg_file_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_BUSY = 1'b0;
  logic          RF_WrEn;
  logic          RF_RdEn;
  logic [AW-1:0] RF_Address;
  logic [DW-1:0] RF_WrData;
  logic [DW-1:0] RF_RdData = '0;
  logic          CMD_ERR;

  reg_file_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .TX_BUSY   (TX_BUSY),
    .RF_WrEn   (RF_WrEn),
    .RF_RdEn   (RF_RdEn),
    .RF_Address(RF_Address),
    .RF_WrData (RF_WrData),
    .RF_RdData (RF_RdData),
    .CMD_ERR   (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Register file model: registered read, one cycle after RF_RdEn.
  logic [DW-1:0] mem [8] = '{default: '0};
  always @(posedge CLK) begin
    if (RF_WrEn) mem[RF_Address] <= RF_WrData;
    if (RF_RdEn) RF_RdData <= mem[RF_Address];
  end

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [7:0]  data;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t tx_q[$];
  exp_t err_q[$];

  int checks = 0;
  int failures = 0;

  function automatic void exp_wr(int c, logic [7:0] a, logic [7:0] d);
    wr_q.push_back('{cyc: c, addr: a, data: d});
  endfunction
  function automatic void exp_rd(int c, logic [7:0] a);
    rd_q.push_back('{cyc: c, addr: a, data: 8'h00});
  endfunction
  function automatic void exp_tx(int c, logic [7:0] d);
    tx_q.push_back('{cyc: c, addr: 8'h00, data: d});
  endfunction
  function automatic void exp_err(int c);
    err_q.push_back('{cyc: c, addr: 8'h00, data: 8'h00});
  endfunction

  // Monitor: every observed strobe must match the oldest expectation of its kind.
  always @(negedge CLK) begin
    exp_t e;
    if (RF_WrEn && RF_RdEn) begin
      checks++; failures++;
      $display("FAIL wr_rd_exclusive: got WrEn=1 RdEn=1 at cycle %0d, required never both", cyc);
    end
    if (RF_WrEn) begin
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_strobe: got write addr=%0d data=%02h at cycle %0d, required none", RF_Address, RF_WrData, cyc);
      end else begin
        e = wr_q.pop_front();
        if (e.cyc != cyc || e.addr != 8'(RF_Address) || e.data != RF_WrData) begin
          failures++;
          $display("FAIL wr_strobe: got cyc=%0d addr=%0d data=%02h, required cyc=%0d addr=%0d data=%02h", cyc, RF_Address, RF_WrData, e.cyc, e.addr, e.data);
        end else $display("wr   cyc=%0d addr=%0d data=%02h ok", cyc, RF_Address, RF_WrData);
      end
    end
    if (RF_RdEn) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_strobe: got read addr=%0d at cycle %0d, required none", RF_Address, cyc);
      end else begin
        e = rd_q.pop_front();
        if (e.cyc != cyc || e.addr != 8'(RF_Address)) begin
          failures++;
          $display("FAIL rd_strobe: got cyc=%0d addr=%0d, required cyc=%0d addr=%0d", cyc, RF_Address, e.cyc, e.addr);
        end else $display("rd   cyc=%0d addr=%0d ok", cyc, RF_Address);
      end
    end
    if (TX_D_VLD) begin
      checks++;
      if (tx_q.size() == 0) begin
        failures++;
        $display("FAIL tx_strobe: got tx data=%02h at cycle %0d, required none", TX_P_DATA, cyc);
      end else begin
        e = tx_q.pop_front();
        if (e.cyc != cyc || e.data != TX_P_DATA) begin
          failures++;
          $display("FAIL tx_strobe: got cyc=%0d data=%02h, required cyc=%0d data=%02h", cyc, TX_P_DATA, e.cyc, e.data);
        end else $display("tx   cyc=%0d data=%02h ok", cyc, TX_P_DATA);
      end
    end
    if (CMD_ERR) begin
      checks++;
      if (err_q.size() == 0) begin
        failures++;
        $display("FAIL cmd_err: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = err_q.pop_front();
        if (e.cyc != cyc) begin
          failures++;
          $display("FAIL cmd_err: got pulse at cycle %0d, required cycle %0d", cyc, e.cyc);
        end else $display("err  cyc=%0d ok", cyc);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int n);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    n = cyc;
    tick();
    RX_D_VLD  = 1'b0;
    RX_P_DATA = '0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (TX_P_DATA !== '0 || TX_D_VLD !== 1'b0 || RF_WrEn !== 1'b0 || RF_RdEn !== 1'b0 ||
        RF_Address !== '0 || RF_WrData !== '0 || CMD_ERR !== 1'b0) begin
      failures++;
      $display("FAIL %s: got tx=%02h txv=%b we=%b re=%b addr=%0d wd=%02h err=%b, required all zero",
               name, TX_P_DATA, TX_D_VLD, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, CMD_ERR);
    end else $display("%s outputs all zero ok", name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, n2, n3, n4, n5;

    repeat (3) tick();
    check_zero("reset_state");
    RST = 1'b1;
    repeat (2) tick();

    // Write 0x3C to reg 5, then read it back.
    send(8'hAA, n0); send(8'h05, n1); send(8'h3C, n2);
    exp_wr(n2 + 1, 8'd5, 8'h3C);
    send(8'hBB, n3); send(8'h05, n4);
    exp_rd(n4 + 1, 8'd5);
    exp_tx(n4 + 3, 8'h3C);
    repeat (5) tick();

    // Bad opcode, then out-of-range address.
    send(8'h12, n0);
    exp_err(n0 + 1);
    repeat (3) tick();
    send(8'hAA, n0); send(8'h08, n1);
    exp_err(n1 + 1);
    repeat (3) tick();

    // Backpressure: reg 2 = 0x7E, busy high 10 cycles, stray byte while waiting.
    send(8'hAA, n0); send(8'h02, n1); send(8'h7E, n2);
    exp_wr(n2 + 1, 8'd2, 8'h7E);
    repeat (2) tick();
    TX_BUSY = 1'b1;
    send(8'hBB, n0); send(8'h02, n1);
    exp_rd(n1 + 1, 8'd2);
    repeat (2) tick();
    send(8'h99, n2);
    exp_err(n2 + 1);
    while (cyc < n0 + 10) tick();
    TX_BUSY = 1'b0;
    exp_tx(n0 + 11, 8'h7E);
    repeat (4) tick();

    // Reset mid-frame: AA,03 then reset; 55 afterwards is a bad opcode.
    send(8'hAA, n0); send(8'h03, n1);
    RST = 1'b0;
    tick();
    check_zero("reset_mid_frame");
    tick();
    RST = 1'b1;
    tick();
    send(8'h55, n0);
    exp_err(n0 + 1);
    repeat (2) tick();
    send(8'hBB, n0); send(8'h03, n1);
    exp_rd(n1 + 1, 8'd3);
    exp_tx(n1 + 3, 8'h00);
    repeat (4) tick();

    // Back-to-back writes with no gap, then read back reg 1.
    send(8'hAA, n0); send(8'h01, n1); send(8'h11, n2);
    exp_wr(n2 + 1, 8'd1, 8'h11);
    send(8'hAA, n3); send(8'h02, n4); send(8'h22, n5);
    exp_wr(n5 + 1, 8'd2, 8'h22);
    send(8'hBB, n0); send(8'h01, n1);
    exp_rd(n1 + 1, 8'd1);
    exp_tx(n1 + 3, 8'h11);
    repeat (4) tick();

`ifdef CMD_TIMEOUT_EN
    // Read opcode then silence: expiry after 16 counted cycles in RD_ADDR.
    send(8'hBB, n0);
    exp_err(n0 + 17);
    repeat (20) tick();
    send(8'hAA, n0); send(8'h01, n1); send(8'hFF, n2);
    exp_wr(n2 + 1, 8'd1, 8'hFF);
    repeat (3) tick();
`endif

    repeat (5) tick();
    checks++;
    if (wr_q.size() + rd_q.size() + tx_q.size() + err_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d wr %0d rd %0d tx %0d err still pending, required 0",
               wr_q.size(), rd_q.size(), tx_q.size(), err_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Byte-command controller directly upstream of the 8-bit register file. It parses a byte stream from the receive stage into write and read frames, and drives the register file's write-enable, read-enable, address and write-data inputs. On a read it captures the register file's registered read data and hands it to the transmit stage over a valid/busy handshake. It is the only master of the register file port.

## Interface
Parameters:
- DATA_WIDTH, 8, width of bytes and of register file data
- ADDR_WIDTH, 3, register file address width
- TIMEOUT_CYCLES, 1024, idle cycles allowed inside a partial frame (used only with the timeout feature)

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- TX_P_DATA  out  DATA_WIDTH  read-data byte to transmitter
- TX_D_VLD  out  1  one-cycle strobe, TX_P_DATA valid
- TX_BUSY  in  1  transmitter cannot accept a byte
- RF_WrEn  out  1  register file write enable
- RF_RdEn  out  1  register file read enable
- RF_Address  out  ADDR_WIDTH  register file address
- RF_WrData  out  DATA_WIDTH  register file write data
- RF_RdData  in  DATA_WIDTH  register file read data, valid the cycle after RF_RdEn
- CMD_ERR  out  1  one-cycle pulse on a dropped or malformed frame

## Operation
- Frames:
  - Write: 0xAA, addr, data.
  - Read: 0xBB, addr.
- The addr byte uses its low ADDR_WIDTH bits. Any nonzero upper bit drops the frame: CMD_ERR pulses and the FSM returns to IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND.
  - IDLE: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> stay in IDLE, CMD_ERR pulse.
  - WR_ADDR: valid addr byte latched -> WR_DATA.
  - WR_DATA: byte -> RF_WrEn=1 with latched address and data for exactly one cycle -> IDLE.
  - RD_ADDR: valid addr byte -> RF_RdEn=1 for one cycle -> RD_WAIT.
  - RD_WAIT: unconditional -> RD_SEND.
  - RD_SEND: while TX_BUSY=1, wait. When TX_BUSY=0, TX_P_DATA<=RF_RdData and TX_D_VLD=1 for one cycle -> IDLE.
- RF_RdData is stable in RD_SEND because the controller issues no other register file access.
- RX_D_VLD in RD_WAIT or RD_SEND: byte dropped, CMD_ERR pulses, read continues.
- RF_WrEn and RF_RdEn are never high together.
- All outputs are registered.

## Timing
- Reset value of every output is 0, including RF_Address, RF_WrData and TX_P_DATA. Reset forces IDLE.
- Reset mid-frame discards the partial frame. No register file strobe is issued after reset release until a new complete frame arrives.
- Write latency: data byte strobe in cycle N -> RF_WrEn high in N+1.
- Read latency:
  - Address byte strobe in N -> RF_RdEn high in N+1.
  - RF_RdData valid in N+2.
  - TX_D_VLD high in N+3 if TX_BUSY=0 in N+2; otherwise one cycle after the first cycle with TX_BUSY=0.
- Back-to-back frames: a new command byte is accepted in the cycle immediately after returning to IDLE, i.e. the cycle RF_WrEn or TX_D_VLD is high.
- CMD_ERR is high for exactly one cycle per offending byte, in the cycle after that byte.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A cycle counter clears on every accepted byte and counts while in WR_ADDR, WR_DATA or RD_ADDR.
  - If it reaches TIMEOUT_CYCLES-1 with no byte, the FSM goes to IDLE, CMD_ERR pulses and no register file strobe is issued.
  - A byte arriving in the expiry cycle takes priority over the timeout.
- CMD_TIMEOUT_EN undefined: no counter is built, and partial frames wait indefinitely.

## Structure
- Shared package reg_ctrl_pkg:
  - Opcode constants WR_CMD=8'hAA, RD_CMD=8'hBB.
  - FSM state enum.
  - Default widths.
- Sub-module cmd_timer: a timeout counter with clear, enable and expiry outputs. It is instantiated only under CMD_TIMEOUT_EN.

## Test plan
- Write then read: bytes AA,05,3C then BB,05 -> RF_WrEn one cycle with Address=5 and WrData=0x3C; then RF_RdEn with Address=5, and TX_D_VLD with TX_P_DATA=0x3C three cycles after the address strobe.
- Bad opcode and bad address:
  - Byte 0x12 in IDLE -> CMD_ERR pulse, no RF strobe.
  - AA,08 -> CMD_ERR, no write.
- Transmit backpressure: TX_BUSY held high for 10 cycles during a read of reg 2 (=0x7E) -> TX_D_VLD is not asserted until the cycle after TX_BUSY falls, then TX_P_DATA=0x7E; extra RX byte during the wait -> CMD_ERR, read still completes.
- Reset mid-frame: AA,03, then RST low for 2 cycles, then 55 -> no RF_WrEn, all outputs 0 during reset, and 55 is treated as a bad opcode.
- Timeout with CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: BB, then silence -> CMD_ERR pulse 16 cycles later and return to IDLE; a following AA,01,FF completes normally.
- Back-to-back: AA,01,11 immediately followed by AA,02,22 with no gap -> two RF_WrEn pulses with the correct addresses and data.
